cdc_handshake_receiver: RTL

Receive side of a toggle-based request/acknowledge clock-domain crossing. The remote domain holds a data word stable and toggles an asynchronous request line. This block synchronizes the request into the local `clk` domain through a three-stage synchronizer, then captures the word and offers it to a local consumer with a valid/ready handshake. When the consumer accepts the word, the block toggles its acknowledge line back to the sender. It sits between the remote-domain transmitter and local-domain logic, directly downstream of the request synchronizer.

---
 rtl/cdc_pkg.sv | 11 +
 rtl/triple_flop_synchronizer.sv | 46 ++++
 rtl/cdc_handshake_receiver.sv | 111 +++++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle request/acknowledge CDC receiver.
package cdc_pkg;

  localparam int unsigned SYNC_STAGES = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_e;

endpackage : cdc_pkg

// File: rtl/triple_flop_synchronizer.sv
// Multi-flop level synchronizer with hold enable; async or sync reset by AT_POSEDGE_RST.
module triple_flop_synchronizer
  import cdc_pkg::*;
#(
  parameter bit AT_POSEDGE_RST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic d_async,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = sync_q;
    if (enable) begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
    end
  end

  generate
    if (AT_POSEDGE_RST) begin : g_async_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q <= sync_d;
        end
      end
    end else begin : g_sync_rst
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q <= sync_d;
        end
      end
    end
  endgenerate

  assign q = sync_q[SYNC_STAGES-1];

endmodule : triple_flop_synchronizer

// File: rtl/cdc_handshake_receiver.sv
// Receive side of a toggle req/ack CDC: synchronize request, capture word, offer via valid/ready.
// Optional even-parity check on the crossed word: define CDC_HANDSHAKE_RECEIVER_PARITY_EN.
module cdc_handshake_receiver
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter bit          AT_POSEDGE_RST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  req_toggle_async,
  input  logic [DATA_WIDTH-1:0] data_async,
`ifdef CDC_HANDSHAKE_RECEIVER_PARITY_EN
  input  logic                  parity_async,
  output logic                  parity_error,
`endif
  output logic                  ack_toggle,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic                  req_sync;
  state_e                state_q, state_d;
  logic                  req_seen_q, req_seen_d;
  logic                  ack_q, ack_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
`ifdef CDC_HANDSHAKE_RECEIVER_PARITY_EN
  logic                  perr_q, perr_d;
`endif

  triple_flop_synchronizer #(
    .AT_POSEDGE_RST (AT_POSEDGE_RST)
  ) u_req_sync (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .d_async (req_toggle_async),
    .q       (req_sync)
  );

  // Capture on a new request level; hand back an ack toggle on each accepted word.
  always_comb begin
    state_d    = state_q;
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    valid_d    = valid_q;
    data_d     = data_q;
`ifdef CDC_HANDSHAKE_RECEIVER_PARITY_EN
    perr_d     = perr_q;
`endif
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (req_sync != req_seen_q) begin
            data_d     = data_async;
            req_seen_d = req_sync;
            valid_d    = 1'b1;
            state_d    = VALID;
`ifdef CDC_HANDSHAKE_RECEIVER_PARITY_EN
            perr_d     = ^{data_async, parity_async};
`endif
          end
        end
        VALID: begin
          if (out_ready) begin
            ack_d   = ~ack_q;
            valid_d = 1'b0;
            state_d = IDLE;
`ifdef CDC_HANDSHAKE_RECEIVER_PARITY_EN
            perr_d  = 1'b0;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
`ifdef CDC_HANDSHAKE_RECEIVER_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
`ifdef CDC_HANDSHAKE_RECEIVER_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  assign ack_toggle = ack_q;
  assign out_data   = data_q;
  assign out_valid  = valid_q;
`ifdef CDC_HANDSHAKE_RECEIVER_PARITY_EN
  assign parity_error = perr_q;
`endif

endmodule : cdc_handshake_receiver
